// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 access encodings
// and the transaction state enum.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: alignment check, byte enables, store replication
// and load extraction with sign/zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_misalign = 1'b0;
    o_be       = 4'b1111;
    o_wdata    = i_wdata;
    o_rdata    = w_shift;
    case (i_funct3)
      F3_B, F3_BU: begin
        if (i_store) begin
          o_be    = 4'b0001 << i_off;
          o_wdata = {4{i_wdata[7:0]}};
        end
        o_rdata = (i_funct3 == F3_B) ? {{24{w_shift[7]}}, w_shift[7:0]}
                                     : {24'b0, w_shift[7:0]};
      end
      F3_H, F3_HU: begin
        o_misalign = i_off[0];
        if (i_store) begin
          o_be    = 4'b0011 << {i_off[1], 1'b0};
          o_wdata = {2{i_wdata[15:0]}};
        end
        o_rdata = (i_funct3 == F3_H) ? {{16{w_shift[15]}}, w_shift[15:0]}
                                     : {16'b0, w_shift[15:0]};
      end
      // Word and any unused encoding behave as a full word access.
      default: begin
        o_misalign = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I MEM-stage load/store unit: issues one handshaked data-memory access per
// instruction, stalls the pipeline while it is outstanding and bounds the ack wait.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       read_data,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] addr,
  output logic              mreq,
  output logic              write,
  output logic [3:0]        be,
  output logic [31:0]       wr_data,
  input  logic [31:0]       rd_data,
  input  logic              ack
);

  state_e             r_state, w_state_next;
  logic [7:0]         r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_write;
  logic [3:0]         r_be;
  logic [31:0]        r_wr_data;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic [31:0]        r_read_data;
  logic               r_misalign;
  logic               r_bus_err;

  logic               w_start;
  logic               w_timeout;
  logic               w_mis;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_ld_data;
  logic [31:0]        w_iss_rdata;
  logic               w_res_mis;
  logic [3:0]         w_res_be;
  logic [31:0]        w_res_wdata;
  logic               w_unused;

  assign w_start   = valid_i & (mem_read | mem_write);
  assign w_timeout = ~ack & (r_cnt == 8'(MAX_WAIT - 1));

  lsu_align u_issue (
    .i_funct3   (funct3),
    .i_off      (address[1:0]),
    .i_store    (mem_write),
    .i_wdata    (write_data),
    .i_rdata    (rd_data),
    .o_misalign (w_mis),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_iss_rdata)
  );

  lsu_align u_result (
    .i_funct3   (r_funct3),
    .i_off      (r_off),
    .i_store    (r_write),
    .i_wdata    (r_wr_data),
    .i_rdata    (rd_data),
    .o_misalign (w_res_mis),
    .o_be       (w_res_be),
    .o_wdata    (w_res_wdata),
    .o_rdata    (w_ld_data)
  );

  // Each instance only contributes half of its outputs.
  assign w_unused = ^{w_iss_rdata, w_res_mis, w_res_be, w_res_wdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_state_next = w_mis ? DONE : BUSY;
      end
      BUSY: begin
        if (ack || w_timeout) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o = ((r_state == IDLE) & w_start) | (r_state == BUSY);
    mreq    = (r_state == BUSY);
    done_o  = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_be        <= '0;
      r_wr_data   <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_read_data <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr      <= {address[ADDR_W-1:2], 2'b00};
            r_write     <= mem_write;
            r_be        <= w_be;
            r_wr_data   <= w_wdata;
            r_funct3    <= funct3;
            r_off       <= address[1:0];
            r_read_data <= '0;
            r_misalign  <= w_mis;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
          end
        end
        BUSY: begin
          if (ack) begin
            if (!r_write) r_read_data <= w_ld_data;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) r_bus_err <= 1'b1;
          end
        end
        DONE: begin
          // Flags are single-cycle pulses alongside done_o.
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign addr       = r_addr;
  assign write      = r_write;
  assign be         = r_be;
  assign wr_data    = r_wr_data;
  assign read_data  = r_read_data;
  assign misalign_o = r_misalign;
  assign bus_err_o  = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        stall_o;
  logic        done_o;
  logic [31:0] read_data;
  logic        misalign_o;
  logic        bus_err_o;
  logic [31:0] addr;
  logic        mreq;
  logic        write;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;

  int total = 0;
  int bad   = 0;

  logic [2:0] f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  mem_access_unit #(
    .ADDR_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .write_data (write_data),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .read_data  (read_data),
    .misalign_o (misalign_o),
    .bus_err_o  (bus_err_o),
    .addr       (addr),
    .mreq       (mreq),
    .write      (write),
    .be         (be),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .ack        (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access width in bytes and signedness, straight from the funct3 table.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    int off;
    if (!st) return 4'b1111;
    m = 4'b0000;
    off = int'(a % 4);
    for (int i = 0; i < nbytes(f3); i++) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint v;
    longint span;
    int n;
    n = nbytes(f3);
    if (n == 4) return rd;
    span = longint'(1) << (8 * n);
    v = longint'({32'b0, rd}) >> (8 * int'(a % 4));
    v = v % span;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // k = BUSY cycle in which ack is raised; 0 means never acknowledge.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int k, input logic [31:0] rdat);
    bit          mis;
    int          lim;
    logic [31:0] exp_rd;
    mis    = ref_misaligned(f3, a);
    lim    = (k == 0) ? int'(MAX_WAIT) : k;
    exp_rd = (wr || mis || k == 0) ? 32'h0 : ref_load(f3, a, rdat);
    @(negedge clk);
    valid_i = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    address = a; write_data = wd; rd_data = rdat;
    #1;
    check("stall_c0", stall_o, 1);
    check("mreq_c0", mreq, 0);
    if (mis) begin
      @(negedge clk);
      check("mis_done", done_o, 1);
      check("mis_flag", misalign_o, 1);
      check("mis_mreq", mreq, 0);
      check("mis_buserr", bus_err_o, 0);
      check("mis_stall", stall_o, 0);
      check("mis_rdata", read_data, 0);
    end else begin
      for (int c = 1; c <= lim; c++) begin
        @(negedge clk);
        check("busy_mreq", mreq, 1);
        check("busy_stall", stall_o, 1);
        check("busy_done", done_o, 0);
        check("busy_addr", addr, {a[31:2], 2'b00});
        check("busy_be", be, ref_be(wr, f3, a));
        check("busy_write", write, wr);
        if (wr) check("busy_wdata", wr_data, ref_wdata(f3, wd));
        if (c == k) ack = 1'b1;
      end
      @(negedge clk);
      ack = 1'b0;
      check("done", done_o, 1);
      check("done_rdata", read_data, exp_rd);
      check("done_buserr", bus_err_o, (k == 0));
      check("done_mis", misalign_o, 0);
      check("done_stall", stall_o, 0);
      check("done_mreq", mreq, 0);
    end
    // valid_i stays high through DONE; it must not retrigger the access.
    @(negedge clk);
    valid_i = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check("idle_stall", stall_o, 0);
    check("idle_mreq", mreq, 0);
    check("idle_done", done_o, 0);
    check("idle_mis", misalign_o, 0);
    check("idle_buserr", bus_err_o, 0);
  endtask

  initial begin
    bit          r_wr;
    bit          r_rd;
    logic [2:0]  r_f3;

    rst_n = 1'b0; valid_i = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
    address = 32'h0; write_data = 32'h0; rd_data = 32'h0; ack = 1'b0;
    #12;
    check("rst_mreq", mreq, 0);
    check("rst_write", write, 0);
    check("rst_be", be, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wr_data, 0);
    check("rst_rdata", read_data, 0);
    check("rst_done", done_o, 0);
    check("rst_mis", misalign_o, 0);
    check("rst_buserr", bus_err_o, 0);
    check("rst_stall", stall_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0);   // SW
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);   // LB
    access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);   // LBU
    access(1'b0, 1'b1, 3'b000, 32'h0000_0202, 32'h0000_00AB, 2, 32'h0);   // SB
    access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 1, 32'h0);   // SH
    access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1, 32'h1111_1111);   // LW misaligned
    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 3, 32'h8001_7FFF);   // LH
    access(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h0);   // store wins
    access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 0, 32'h5555_5555);   // timeout

    // Non-memory instruction and a stray ack in IDLE.
    @(negedge clk);
    valid_i = 1'b1; ack = 1'b1;
    #1;
    check("nomem_stall", stall_o, 0);
    @(negedge clk);
    check("nomem_done", done_o, 0);
    check("nomem_mreq", mreq, 0);
    valid_i = 1'b0; ack = 1'b0;

    // Reset in the third BUSY cycle of a load.
    @(negedge clk);
    valid_i = 1'b1; mem_read = 1'b1; funct3 = 3'b010; address = 32'h0000_0040;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    check("pre_rst_mreq", mreq, 1);
    rst_n = 1'b0; valid_i = 1'b0; mem_read = 1'b0;
    #1;
    check("midrst_mreq", mreq, 0);
    check("midrst_stall", stall_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_addr", addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 1, 32'h0BAD_C0DE);

    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_rd = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r_f3 = r_wr ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
      access(r_rd, r_wr, r_f3, $urandom, $urandom, int'($urandom_range(1, 4)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit for the RV32I MEM stage. It replaces the pass-through memory stage with a handshaked data-memory transaction that supports:
- byte, halfword and word access;
- byte enables;
- sign and zero extension;
- misalignment detection;
- a bounded wait for the memory acknowledge.

It sits between EX/MEM and MEM/WB and stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width (low ADDR_W bits of address are used).
- MAX_WAIT, 15, BUSY cycles without ack before bus error (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  EX/MEM holds a valid instruction.
- mem_read  in  1  load.
- mem_write  in  1  store; has priority if both are set.
- funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- address  in  32  effective address.
- write_data  in  32  store data (rs2).
- stall_o  out  1  hold IF..EX/MEM this cycle.
- done_o  out  1  one-cycle pulse: access finished.
- read_data  out  32  extended load result, valid while done_o.
- misalign_o  out  1  pulse with done_o: access was misaligned, no bus cycle issued.
- bus_err_o  out  1  pulse with done_o: ack timeout.
- addr  out  ADDR_W  word-aligned memory address ({address[ADDR_W-1:2],2'b00}).
- mreq  out  1  memory request, held until ack.
- write  out  1  1 = store, 0 = load; valid with mreq.
- be  out  4  byte enables.
- wr_data  out  32  lane-replicated store data.
- rd_data  in  32  memory read word, sampled on ack.
- ack  in  1  memory accepts the store or returns rd_data this cycle.

## Operation
States:
- **IDLE**
  - start = valid_i & (mem_read | mem_write).
  - On start, latch addr, write, be, wr_data, funct3 and byte offset into registers.
  - If aligned, go to BUSY. If misaligned, go to DONE with the misalign flag set.
- **BUSY**
  - mreq=1; addr, write, be and wr_data are driven from the latched registers and stay stable.
  - On ack: capture the extended rd_data (loads), then go to DONE.
  - Wait counter increments each BUSY cycle without ack. When it reaches MAX_WAIT, go to DONE with the bus-error flag set. mreq drops on that transition.
- **DONE**
  - done_o=1; read_data, misalign_o and bus_err_o are driven from registers.
  - Next state: IDLE.

Alignment rules:
- H/HU/SH require address[0]=0.
- W/SW require address[1:0]=0.
- B is always aligned.

Byte enables:
- SB: be = 4'b0001<<off, where off = address[1:0].
- SH: be = 4'b0011<<{off[1],1'b0}.
- SW: be = 4'b1111.
- Loads: be = 4'b1111.

Store data is replicated across lanes:
- SB: {4{b}}.
- SH: {2{h}}.
- SW: the word unchanged.

Load extraction:
- Shift rd_data right by off*8.
- B/H sign-extend bit 7/15; BU/HU zero-extend; W is unchanged.

Other behaviour:
- Stores return read_data=0.
- Non-memory instructions (start=0) pass through: no stall, no done_o.

## Timing
- Reset values: state=IDLE, mreq=0, write=0, be=0, addr=0, wr_data=0, read_data=0, done_o=0, misalign_o=0, bus_err_o=0, counter=0.
- stall_o is combinational: (IDLE & start) | BUSY. It is low in DONE, so the pipeline advances at the end of DONE.
- Latency, with ack in the k-th BUSY cycle: start in IDLE at cycle 0 → mreq high from cycles 1..k → done_o at cycle k+1.
  - Zero-wait memory (ack in the first BUSY cycle): done_o at cycle 2.
- Misaligned access: IDLE→DONE; done_o at cycle 1 with misalign_o=1, and mreq never rises.
- Timeout: bus_err_o and done_o are asserted in the cycle after the counter reaches MAX_WAIT.
- An ack that arrives while not in BUSY is ignored.
- The instruction is re-sampled only in IDLE; valid_i held during DONE does not restart the access.
- Reset asserted mid-BUSY drops mreq asynchronously. No done_o is produced, and the memory must abandon the access.

## Structure
- Shared package mem_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, BUSY, DONE).
- Combinational sub-module lsu_align handles the alignment check, be/wr_data generation and load extraction/extension. It is instantiated twice: once on live inputs at issue, once on latched state for the load result.

## Test plan
- SW: address 0x100, write_data 0xDEADBEEF, ack on the first BUSY cycle → addr=0x100, be=1111, wr_data=0xDEADBEEF, write=1, done_o at cycle 2, stall high for 2 cycles.
- LB / LBU: address 0x103, rd_data 0x80FF_1234 → LB gives read_data=0xFFFFFF80 and LBU gives 0x00000080.
- SB: address 0x202, data 0x000000AB → be=0100, wr_data=0xABABABAB. SH at 0x202, data 0x1234 → be=1100, wr_data=0x12341234.
- LW at address 0x101 → misalign_o=1 with done_o at cycle 1, mreq stays 0. LH at 0x102 is accepted.
- Load with MAX_WAIT=15 and ack never raised → mreq high for 15 cycles, then bus_err_o=1 and done_o=1, state returns to IDLE.
- rst_n pulled low in the 3rd BUSY cycle → mreq, stall_o and done_o go to 0 immediately. After release, a new LW completes normally.
